dma_channel_scheduler: RTL and testbench
========================================

Name: dma_channel_scheduler

Overview:
Registered request scheduler for the 4-channel DMA controller. It merges hardware DREQ lines, mask bits and software requests. It runs the HRQ/HLDA bus-hold handshake with the CPU and arbitrates the channels using fixed or rotating priority. It holds a one-hot DACK for the whole transfer until the transfer engine reports completion, and on completion updates the rotating priority order.

Parameters:
NUM_CH, 4, number of DMA channels; only 4 is supported (DACK/DREQ one-hot width).
IDLE_GAP, 1, cycles spent in RELEASE with HRQ low before a new request may be raised; legal range 1..15.

Ports:
CLK  input  1  system clock; all logic on rising edge
RESET  input  1  synchronous, active-high reset
DREQ  input  4  hardware channel requests, active-high, level
maskReg  input  4  per-channel mask; 1 = DREQ ignored
softReq  input  4  software request bits; not affected by maskReg
priorityType  input  1  0 = fixed priority, 1 = rotating priority
controllerDisable  input  1  1 = no new hold requests are started
HLDA  input  1  hold acknowledge from the CPU
xferDone  input  1  one-cycle pulse from the transfer engine: granted channel finished
HRQ  output  1  hold request to the CPU
DACK  output  4  one-hot channel acknowledge, active-high
activeChannel  output  2  index of the granted channel; valid while DACK != 0
grantPulse  output  1  high only in the first cycle of each DACK assertion
holdLost  output  1  one-cycle pulse when HLDA drops during XFER
priorityOrder  output  8  current rotating order, [1:0] = highest priority channel

Behaviour:
- Effective request: req = (DREQ & ~maskReg) | softReq, evaluated combinationally every cycle.
- All outputs are registered.
- Reset (RESET=1 at a clock edge):
  - state=IDLE, HRQ=0, DACK=0, activeChannel=0, grantPulse=0, holdLost=0.
  - priorityOrder = {2'd3,2'd2,2'd1,2'd0}, so channel 0 is highest.
  - Reset overrides everything in the same cycle, including mid-transfer; DACK and HRQ are 0 on the next cycle.
- States: IDLE, HOLD_REQ, XFER, RELEASE.
- IDLE: when req != 0 and controllerDisable=0, next state is HOLD_REQ and HRQ=1 from the next cycle. This gives 1-cycle latency from req to HRQ.
- HOLD_REQ: HRQ stays 1.
  - If HLDA=1 and req != 0: arbitrate on this cycle's req and latch the winner. Next state is XFER, with DACK[winner]=1, activeChannel=winner and grantPulse=1 on the next cycle.
  - Else if req==0 or controllerDisable=1: go to RELEASE; no grant is made.
  - Otherwise wait indefinitely; there is no timeout.
- Arbitration:
  - Fixed priority: lowest-index requesting channel wins.
  - Rotating priority: first requesting channel in priorityOrder[1:0], [3:2], [5:4], [7:6] wins.
  - A priorityType change takes effect at the next arbitration; the priorityOrder register is retained across mode changes.
- XFER:
  - HRQ=1 and DACK is held on the latched channel regardless of later DREQ, mask, softReq or controllerDisable changes.
  - Exactly one DACK bit is set.
  - grantPulse=0 after the first XFER cycle.
- XFER exit on xferDone=1:
  - Next state is RELEASE; DACK=0 and HRQ=0 on the next cycle.
  - If priorityType=1, rotate so the serviced channel k becomes lowest: order = k+1,k+2,k+3,k (mod 4).
  - In fixed mode, priorityOrder is unchanged.
- XFER exit on HLDA=0 (without xferDone):
  - Abort: next state is RELEASE, DACK=0, HRQ=0, holdLost=1 for one cycle.
  - No rotation.
  - If xferDone and HLDA=0 arrive in the same cycle, xferDone takes precedence: normal completion, no holdLost.
- RELEASE: HRQ=0 and DACK=0 for exactly IDLE_GAP cycles (down-counter), then IDLE. Requests are ignored during RELEASE.
- xferDone outside XFER is ignored.
- HLDA outside HOLD_REQ/XFER is ignored.
- Minimum turnaround between transfers: completion cycle → RELEASE (IDLE_GAP cycles) → IDLE (1 cycle) → HRQ.

Test Plan:
- Fixed priority:
  - Stimulus: RESET, priorityType=0, DREQ=4'b1010, HLDA rises 3 cycles after HRQ.
  - Response: HRQ=1 one cycle after DREQ; DACK=4'b0010, activeChannel=1 and grantPulse=1 one cycle after HLDA; DACK held until xferDone; DACK=0 and HRQ=0 the cycle after.
- Rotating priority:
  - Stimulus: priorityType=1, DREQ=4'b1111 constant, four back-to-back transfers each closed by xferDone.
  - Response: DACK sequence 0001, 0010, 0100, 1000; priorityOrder after the first transfer = {0,3,2,1}.
- Mask and software request:
  - Stimulus: maskReg=4'b0001, DREQ=4'b0001, softReq=0.
  - Response: HRQ stays 0 for 10 cycles.
  - Then set softReq=4'b0100 → DACK=4'b0100 after HLDA.
- Hold lost:
  - Stimulus: during XFER on channel 2, drop HLDA with no xferDone.
  - Response: holdLost=1 for one cycle, DACK=0, HRQ=0, priorityOrder unchanged, RELEASE lasts IDLE_GAP cycles.
- Request withdrawn and disable:
  - Stimulus: DREQ pulse removed while in HOLD_REQ before HLDA.
  - Response: HRQ drops the next cycle and no DACK is ever asserted.
  - Stimulus: controllerDisable=1 in IDLE with DREQ=4'b1111 → HRQ stays 0.
- Reset mid-transfer:
  - Stimulus: RESET=1 during XFER on channel 3 (rotating mode, order previously rotated).
  - Response: next cycle DACK=0, HRQ=0, state IDLE, priorityOrder={3,2,1,0}.
  - Then simultaneous xferDone and HLDA=0 in a later transfer → normal completion, holdLost=0.

Source files
------------

// File: rtl/dma_channel_scheduler_if.sv
// Request/acknowledge bundle between the DMA channel scheduler, the CPU hold
// logic and the transfer engine.
interface dma_channel_scheduler_if;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic [3:0] softReq;
    logic       priorityType;
    logic       controllerDisable;
    logic       HLDA;
    logic       xferDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] activeChannel;
    logic       grantPulse;
    logic       holdLost;
    logic [7:0] priorityOrder;

    modport slave (
        input  DREQ, maskReg, softReq, priorityType, controllerDisable, HLDA, xferDone,
        output HRQ, DACK, activeChannel, grantPulse, holdLost, priorityOrder
    );

    modport master (
        output DREQ, maskReg, softReq, priorityType, controllerDisable, HLDA, xferDone,
        input  HRQ, DACK, activeChannel, grantPulse, holdLost, priorityOrder
    );
endinterface

// File: rtl/dma_channel_scheduler.sv
// Four-channel DMA request scheduler: HRQ/HLDA hold handshake, fixed or
// rotating arbitration, and a one-hot DACK held for the whole transfer.
module dma_channel_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_GAP = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    dma_channel_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD_REQ = 2'd1,
        S_XFER     = 2'd2,
        S_RELEASE  = 2'd3
    } state_e;

    localparam logic [3:0] GAP_LOAD   = 4'(IDLE_GAP - 1);
    localparam logic [7:0] ORDER_INIT = {2'd3, 2'd2, 2'd1, 2'd0};

    state_e              state_q, state_d;
    logic [3:0]          gap_q, gap_d;
    logic                hrq_q, hrq_d;
    logic [NUM_CH-1:0]   dack_q, dack_d;
    logic [1:0]          active_q, active_d;
    logic                grant_pulse_q, grant_pulse_d;
    logic                hold_lost_q, hold_lost_d;
    logic [7:0]          order_q, order_d;

    logic [NUM_CH-1:0]   req_s;
    logic [1:0]          winner_s;
    logic                grant_s;
    logic                done_s;
    logic                lost_s;

    // Fixed mode scans channel 0 upward; rotating mode walks the order register.
    function automatic logic [1:0] pick_winner(input logic [3:0] req,
                                               input logic       rotate,
                                               input logic [7:0] order);
        logic [1:0] win;
        logic       found;
        logic [1:0] cand;
        win   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = rotate ? order[2*i +: 2] : 2'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end else begin
                win   = win;
            end
        end
        return win;
    endfunction

    function automatic logic [7:0] rotate_after(input logic [1:0] k);
        return {k, k + 2'd3, k + 2'd2, k + 2'd1};
    endfunction

    assign req_s    = (bus.DREQ & ~bus.maskReg) | bus.softReq;
    assign winner_s = pick_winner(req_s, bus.priorityType, order_q);

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            gap_q         <= 4'd0;
            hrq_q         <= 1'b0;
            dack_q        <= '0;
            active_q      <= 2'd0;
            grant_pulse_q <= 1'b0;
            hold_lost_q   <= 1'b0;
            order_q       <= ORDER_INIT;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            hrq_q         <= hrq_d;
            dack_q        <= dack_d;
            active_q      <= active_d;
            grant_pulse_q <= grant_pulse_d;
            hold_lost_q   <= hold_lost_d;
            order_q       <= order_d;
        end
    end

    // Next-state logic; xferDone wins over a simultaneous HLDA drop.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        grant_s = 1'b0;
        done_s  = 1'b0;
        lost_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((req_s != 4'd0) && !bus.controllerDisable) begin
                    state_d = S_HOLD_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD_REQ: begin
                if (bus.HLDA && (req_s != 4'd0)) begin
                    state_d = S_XFER;
                    grant_s = 1'b1;
                end else if ((req_s == 4'd0) || bus.controllerDisable) begin
                    state_d = S_RELEASE;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = S_HOLD_REQ;
                end
            end
            S_XFER: begin
                if (bus.xferDone) begin
                    state_d = S_RELEASE;
                    gap_d   = GAP_LOAD;
                    done_s  = 1'b1;
                end else if (!bus.HLDA) begin
                    state_d = S_RELEASE;
                    gap_d   = GAP_LOAD;
                    lost_s  = 1'b1;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_RELEASE: begin
                if (gap_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gap_d   = 4'd0;
            end
        endcase
    end

    // Output next values, registered above.
    always_comb begin
        hrq_d         = (state_d == S_HOLD_REQ) || (state_d == S_XFER);
        grant_pulse_d = grant_s;
        hold_lost_d   = lost_s;
        if (grant_s) begin
            dack_d   = NUM_CH'(1) << winner_s;
            active_d = winner_s;
        end else if (state_d == S_XFER) begin
            dack_d   = dack_q;
            active_d = active_q;
        end else begin
            dack_d   = '0;
            active_d = active_q;
        end
        if (done_s && bus.priorityType) begin
            order_d = rotate_after(active_q);
        end else begin
            order_d = order_q;
        end
    end

    assign bus.HRQ           = hrq_q;
    assign bus.DACK          = dack_q;
    assign bus.activeChannel = active_q;
    assign bus.grantPulse    = grant_pulse_q;
    assign bus.holdLost      = hold_lost_q;
    assign bus.priorityOrder = order_q;
endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Directed bench for dma_channel_scheduler with hand-computed expectations.
module tb_dma_channel_scheduler;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   checks_r = 0;
    int   errors_r = 0;

    dma_channel_scheduler_if bus ();

    dma_channel_scheduler #(.NUM_CH(4), .IDLE_GAP(1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_hrq(input string tag);
        int n;
        n = 0;
        while (bus.HRQ !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check_value(tag, 32'(bus.HRQ), 32'd1);
    endtask

    task automatic run_xfer(input string tag, input logic [3:0] exp_dack);
        wait_hrq({tag, "_hrq"});
        bus.HLDA = 1'b1;
        tick(1);
        check_value({tag, "_dack"}, 32'(bus.DACK), 32'(exp_dack));
        check_value({tag, "_gp"}, 32'(bus.grantPulse), 32'd1);
        bus.xferDone = 1'b1;
        tick(1);
        bus.xferDone = 1'b0;
        bus.HLDA     = 1'b0;
        check_value({tag, "_done_dack"}, 32'(bus.DACK), 32'd0);
        check_value({tag, "_done_hrq"}, 32'(bus.HRQ), 32'd0);
    endtask

    initial begin
        bus.DREQ = 4'd0; bus.maskReg = 4'd0; bus.softReq = 4'd0;
        bus.priorityType = 1'b0; bus.controllerDisable = 1'b0;
        bus.HLDA = 1'b0; bus.xferDone = 1'b0;
        tick(2);
        RESET = 1'b0;
        check_value("rst_hrq", 32'(bus.HRQ), 32'd0);
        check_value("rst_dack", 32'(bus.DACK), 32'd0);
        check_value("rst_active", 32'(bus.activeChannel), 32'd0);
        check_value("rst_gp", 32'(bus.grantPulse), 32'd0);
        check_value("rst_lost", 32'(bus.holdLost), 32'd0);
        check_value("rst_order", 32'(bus.priorityOrder), 32'h0000_00e4);

        // Fixed priority, HLDA three cycles after HRQ
        bus.DREQ = 4'b1010;
        tick(1);
        check_value("fx_hrq", 32'(bus.HRQ), 32'd1);
        tick(2);
        check_value("fx_wait_dack", 32'(bus.DACK), 32'd0);
        bus.HLDA = 1'b1;
        tick(1);
        check_value("fx_dack", 32'(bus.DACK), 32'b0010);
        check_value("fx_active", 32'(bus.activeChannel), 32'd1);
        check_value("fx_gp", 32'(bus.grantPulse), 32'd1);
        bus.DREQ = 4'b0001;
        tick(1);
        check_value("fx_gp_low", 32'(bus.grantPulse), 32'd0);
        check_value("fx_hold", 32'(bus.DACK), 32'b0010);
        bus.xferDone = 1'b1;
        tick(1);
        bus.xferDone = 1'b0;
        bus.HLDA = 1'b0;
        bus.DREQ = 4'd0;
        check_value("fx_end_dack", 32'(bus.DACK), 32'd0);
        check_value("fx_end_hrq", 32'(bus.HRQ), 32'd0);
        check_value("fx_order", 32'(bus.priorityOrder), 32'h0000_00e4);
        tick(2);

        // Rotating priority, all channels requesting
        bus.priorityType = 1'b1;
        bus.DREQ = 4'b1111;
        run_xfer("rot0", 4'b0001);
        check_value("rot0_order", 32'(bus.priorityOrder), 32'h0000_0039);
        run_xfer("rot1", 4'b0010);
        run_xfer("rot2", 4'b0100);
        run_xfer("rot3", 4'b1000);
        check_value("rot3_order", 32'(bus.priorityOrder), 32'h0000_00e4);
        bus.DREQ = 4'd0;
        tick(2);

        // Masked DREQ ignored, software request honoured
        bus.maskReg = 4'b0001;
        bus.DREQ = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_value("mask_hrq", 32'(bus.HRQ), 32'd0);
        end
        bus.softReq = 4'b0100;
        wait_hrq("soft_hrq");
        bus.HLDA = 1'b1;
        tick(1);
        check_value("soft_dack", 32'(bus.DACK), 32'b0100);
        tick(1);

        // Hold lost mid-transfer on channel 2
        bus.HLDA = 1'b0;
        tick(1);
        check_value("lost_pulse", 32'(bus.holdLost), 32'd1);
        check_value("lost_dack", 32'(bus.DACK), 32'd0);
        check_value("lost_hrq", 32'(bus.HRQ), 32'd0);
        check_value("lost_order", 32'(bus.priorityOrder), 32'h0000_00e4);
        tick(1);
        check_value("lost_pulse_end", 32'(bus.holdLost), 32'd0);
        check_value("lost_gap_hrq", 32'(bus.HRQ), 32'd0);
        tick(1);
        check_value("lost_rehrq", 32'(bus.HRQ), 32'd1);

        // Request withdrawn before HLDA
        bus.softReq = 4'd0;
        tick(1);
        check_value("wd_hrq", 32'(bus.HRQ), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_value("wd_dack", 32'(bus.DACK), 32'd0);
        end
        bus.maskReg = 4'd0;
        bus.DREQ = 4'd0;

        // Controller disabled
        bus.controllerDisable = 1'b1;
        bus.DREQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_value("dis_hrq", 32'(bus.HRQ), 32'd0);
        end
        bus.DREQ = 4'd0;
        bus.controllerDisable = 1'b0;
        tick(1);

        // Reset during a transfer on channel 3 after a rotation
        bus.DREQ = 4'b0001;
        run_xfer("pre", 4'b0001);
        check_value("pre_order", 32'(bus.priorityOrder), 32'h0000_0039);
        bus.DREQ = 4'b1000;
        wait_hrq("r3_hrq");
        bus.HLDA = 1'b1;
        tick(1);
        check_value("r3_dack", 32'(bus.DACK), 32'b1000);
        check_value("r3_active", 32'(bus.activeChannel), 32'd3);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        bus.HLDA = 1'b0;
        bus.DREQ = 4'd0;
        check_value("r3_rst_dack", 32'(bus.DACK), 32'd0);
        check_value("r3_rst_hrq", 32'(bus.HRQ), 32'd0);
        check_value("r3_rst_order", 32'(bus.priorityOrder), 32'h0000_00e4);
        tick(1);
        check_value("r3_idle_hrq", 32'(bus.HRQ), 32'd0);

        // xferDone and HLDA drop together: normal completion
        bus.DREQ = 4'b0100;
        wait_hrq("sim_hrq");
        bus.HLDA = 1'b1;
        tick(1);
        check_value("sim_dack", 32'(bus.DACK), 32'b0100);
        bus.xferDone = 1'b1;
        bus.HLDA = 1'b0;
        tick(1);
        bus.xferDone = 1'b0;
        bus.DREQ = 4'd0;
        check_value("sim_lost", 32'(bus.holdLost), 32'd0);
        check_value("sim_dack_end", 32'(bus.DACK), 32'd0);
        check_value("sim_hrq_end", 32'(bus.HRQ), 32'd0);
        check_value("sim_order", 32'(bus.priorityOrder), 32'h0000_0093);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end
endmodule
